// File: rtl/fp_sgnj_pipe.sv
// rtl/fp_sgnj_pipe.sv - multi-lane FSGNJ/FSGNJN/FSGNJX unit with 2-entry output FIFO
// Optional input NaN-box checking: define FP_SGNJ_NANBOX_CHECK_EN.
module fp_sgnj_pipe #(
    parameter int LANES = 1,
    parameter int TAG_W = 5
) (
    input  logic                  reset,
    input  logic                  clock,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [64*LANES-1:0]   in_data1,
    input  logic [64*LANES-1:0]   in_data2,
    input  logic [1:0]            in_fmt,
    input  logic [2:0]            in_rm,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*LANES-1:0]   out_result,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_inv
);

    logic                  illegal;
    logic [64*LANES-1:0]   result_d;

    assign illegal = (in_fmt == 2'd3) || (in_rm > 3'd2);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] a_s;
        logic [15:0] a_h;
        logic        sb_s;
        logic        sb_h;
        logic        sa;
        logic        sb;
        logic        sign;
        logic [63:0] res;
        logic        unused_b;

        assign a        = in_data1[64*k +: 64];
        assign b        = in_data2[64*k +: 64];
        assign unused_b = ^b;

`ifdef FP_SGNJ_NANBOX_CHECK_EN
        // Improperly boxed narrow operands read as the canonical NaN (sign 0).
        assign a_s  = (&a[63:32]) ? a[31:0] : 32'h7FC0_0000;
        assign a_h  = (&a[63:16]) ? a[15:0] : 16'h7E00;
        assign sb_s = (&b[63:32]) & b[31];
        assign sb_h = (&b[63:16]) & b[15];
`else
        assign a_s  = a[31:0];
        assign a_h  = a[15:0];
        assign sb_s = b[31];
        assign sb_h = b[15];
`endif

        always_comb begin
            sa   = 1'b0;
            sb   = 1'b0;
            sign = 1'b0;
            res  = '0;
            case (in_fmt)
                2'd0:    begin sa = a_s[31]; sb = sb_s; end
                2'd1:    begin sa = a[63];   sb = b[63]; end
                default: begin sa = a_h[15]; sb = sb_h; end
            endcase
            case (in_rm)
                3'd0:    sign = sb;
                3'd1:    sign = ~sb;
                default: sign = sa ^ sb;
            endcase
            case (in_fmt)
                2'd0:    res = {32'hFFFF_FFFF, sign, a_s[30:0]};
                2'd1:    res = {sign, a[62:0]};
                2'd2:    res = {48'hFFFF_FFFF_FFFF, sign, a_h[14:0]};
                default: res = '0;
            endcase
            if (illegal) begin
                res = '0;
            end
        end

        assign result_d[64*k +: 64] = res;
    end

    logic [64*LANES-1:0] mem_res [2];
    logic [TAG_W-1:0]    mem_tag [2];
    logic [1:0]          mem_inv;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic                push;
    logic                pop;

    // in_ready ignores out_ready, so a full FIFO never takes a push even while popping.
    assign in_ready   = (count != 2'd2);
    assign out_valid  = (count != 2'd0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_result = mem_res[rd_ptr];
    assign out_tag    = mem_tag[rd_ptr];
    assign out_inv    = mem_inv[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            mem_res[0] <= '0;
            mem_res[1] <= '0;
            mem_tag[0] <= '0;
            mem_tag[1] <= '0;
            mem_inv    <= '0;
        end else begin
            if (push) begin
                mem_res[wr_ptr] <= result_d;
                mem_tag[wr_ptr] <= in_tag;
                mem_inv[wr_ptr] <= illegal;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
